// File: rtl/sprite_lane_drawer.sv
// Plots a SPRITE_W x SPRITE_H sprite at a chosen lane, erasing the previous lane first; one pixel per cycle, registered outputs one cycle behind the counters.
// No backpressure: Start is taken only while Busy is low, anything else is dropped; a bad lane gives a one-cycle Err.
module sprite_lane_drawer #(
   parameter int                     SPRITE_W  = 5,
   parameter int                     SPRITE_H  = 9,
   parameter int                     NUM_LANES = 4,
   parameter logic [NUM_LANES*8-1:0] LANE_X    = {8'd132, 8'd78, 8'd24, 8'd6},
   parameter int                     Y_BASE    = 100,
   parameter logic [2:0]             FG_COLOUR = 3'b110,
   parameter logic [2:0]             BG_COLOUR = 3'b000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic [3:0] Lane,
   output logic [7:0] XOut,
   output logic [6:0] YOut,
   output logic [2:0] ColourOut,
   output logic       Plot,
   output logic       Busy,
   output logic       Done,
   output logic       Err
);

   localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [3:0]      target_lane_q, target_lane_d;
   logic [3:0]      drawn_lane_q, drawn_lane_d;
   logic            drawn_valid_q, drawn_valid_d;
   logic [7:0]      x_q, x_d;
   logic [6:0]      y_q, y_d;
   logic [2:0]      colour_q, colour_d;
   logic            plot_q, plot_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic            last_col;
   logic            last_row;
   logic            lane_ok;
   logic [3:0]      pix_lane;

   function automatic logic [7:0] lane_x(input logic [3:0] l);
      logic [7:0] r;
      r = 8'd0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (l == 4'(i)) r = LANE_X[8*i +: 8];
      end
      return r;
   endfunction

   assign last_col = (col_q == CW'(SPRITE_W - 1));
   assign last_row = (row_q == RW'(SPRITE_H - 1));
   assign lane_ok  = (int'(Lane) < NUM_LANES);
   assign pix_lane = (state_q == ERASE) ? drawn_lane_q : target_lane_q;

   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      target_lane_d = target_lane_q;
      drawn_lane_d  = drawn_lane_q;
      drawn_valid_d = drawn_valid_q;
      x_d           = x_q;
      y_d           = y_q;
      colour_d      = colour_q;
      plot_d        = 1'b0;
      done_d        = 1'b0;
      err_d         = 1'b0;

      case (state_q)
         IDLE: begin
            // busy_q still covers the Done cycle, so a held Start waits one more cycle
            if (Start && !busy_q) begin
               if (lane_ok) begin
                  target_lane_d = Lane;
                  col_d         = '0;
                  row_d         = '0;
                  state_d       = (drawn_valid_q && (drawn_lane_q != Lane)) ? ERASE : DRAW;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ERASE, DRAW: begin
            plot_d   = 1'b1;
            x_d      = lane_x(pix_lane) + 8'(col_q);
            y_d      = 7'(Y_BASE) - 7'(row_q);
            colour_d = (state_q == ERASE) ? BG_COLOUR : FG_COLOUR;
            if (!last_col) begin
               col_d = col_q + CW'(1);
            end else begin
               col_d = '0;
               if (!last_row) begin
                  row_d = row_q + RW'(1);
               end else begin
                  row_d = '0;
                  if (state_q == ERASE) begin
                     state_d = DRAW;
                  end else begin
                     state_d       = DONE;
                     drawn_lane_d  = target_lane_q;
                     drawn_valid_d = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE) || (state_q == DONE);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q       <= IDLE;
         col_q         <= '0;
         row_q         <= '0;
         target_lane_q <= '0;
         drawn_lane_q  <= '0;
         drawn_valid_q <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         colour_q      <= '0;
         plot_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         target_lane_q <= target_lane_d;
         drawn_lane_q  <= drawn_lane_d;
         drawn_valid_q <= drawn_valid_d;
         x_q           <= x_d;
         y_q           <= y_d;
         colour_q      <= colour_d;
         plot_q        <= plot_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign XOut      = x_q;
   assign YOut      = y_q;
   assign ColourOut = colour_q;
   assign Plot      = plot_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Err       = err_q;

endmodule

// File: tb/tb_sprite_lane_drawer.sv
// Directed bench for sprite_lane_drawer with a pixel scoreboard fed from a lane-position model.
module tb_sprite_lane_drawer;

   logic       Clock;
   logic       Reset;
   logic       Start;
   logic [3:0] Lane;
   logic [7:0] XOut;
   logic [6:0] YOut;
   logic [2:0] ColourOut;
   logic       Plot;
   logic       Busy;
   logic       Done;
   logic       Err;

   sprite_lane_drawer dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Lane      (Lane),
      .XOut      (XOut),
      .YOut      (YOut),
      .ColourOut (ColourOut),
      .Plot      (Plot),
      .Busy      (Busy),
      .Done      (Done),
      .Err       (Err)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   int cyc        = 0;
   int plot_cnt   = 0;
   int done_cnt   = 0;
   int err_cnt    = 0;
   int busy_cnt   = 0;
   int first_plot = 0;
   int last_plot  = 0;
   int done_cyc   = 0;

   int  lane_x_tab[4] = '{6, 24, 78, 132};
   bit  model_valid   = 1'b0;
   int  model_lane    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pix(input int lx, input int c, input int r, input logic [2:0] col);
      logic [7:0] x;
      logic [6:0] y;
      x = 8'((lx + c) % 256);
      y = 7'(100 - r);
      return {14'd0, x, y, col};
   endfunction

   task automatic push_pass(input int lane, input logic [2:0] col);
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 5; c++)
            exp_q.push_back(pix(lane_x_tab[lane], c, r, col));
   endtask

   task automatic clear_counts();
      plot_cnt = 0;
      done_cnt = 0;
      err_cnt  = 0;
      busy_cnt = 0;
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard on every Plot
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge Clock);
         cyc++;
         if (!Reset) begin
            if (Busy) busy_cnt++;
            if (Err)  err_cnt++;
            if (Done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (Plot) begin
               if (plot_cnt == 0) first_plot = cyc;
               last_plot = cyc;
               plot_cnt++;
               if (exp_q.size() == 0) begin
                  chk("plot_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("pixel", {14'd0, XOut, YOut, ColourOut}, e);
               end
            end
         end
      end
   end

   task automatic run_req(input int lane);
      bit valid;
      bit erase;
      int npix;
      valid = (lane < 4);
      erase = valid && model_valid && (model_lane != lane);
      npix  = erase ? 90 : (valid ? 45 : 0);
      @(negedge Clock);
      clear_counts();
      if (erase) push_pass(model_lane, 3'b000);
      if (valid) push_pass(lane, 3'b110);
      Start = 1'b1;
      Lane  = 4'(lane);
      @(negedge Clock);
      Start = 1'b0;
      if (valid) begin
         for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge Clock);
      end else begin
         repeat (5) @(negedge Clock);
      end
      repeat (3) @(negedge Clock);
      chk("plot_count", 32'(plot_cnt), 32'(npix));
      chk("done_count", 32'(done_cnt), valid ? 32'd1 : 32'd0);
      chk("err_count", 32'(err_cnt), valid ? 32'd0 : 32'd1);
      chk("busy_cycles", 32'(busy_cnt), valid ? 32'(npix + 2) : 32'd0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      if (valid) begin
         chk("plot_contiguous", 32'(last_plot - first_plot + 1), 32'(plot_cnt));
         chk("done_after_last_plot", 32'(done_cyc), 32'(last_plot + 1));
         model_valid = 1'b1;
         model_lane  = lane;
      end
   endtask

   initial begin
      int gap;
      Reset = 1'b0;
      Start = 1'b0;
      Lane  = 4'd0;
      #3 Reset = 1'b1;
      repeat (2) @(negedge Clock);
      chk("reset_xout", 32'(XOut), 32'd0);
      chk("reset_yout", 32'(YOut), 32'd0);
      chk("reset_colour", 32'(ColourOut), 32'd0);
      chk("reset_flags", {28'd0, Plot, Busy, Done, Err}, 32'd0);
      Reset = 1'b0;
      repeat (2) @(negedge Clock);

      run_req(1);   // fresh: draw only at X 24..28
      run_req(3);   // erase lane 1 then draw lane 3
      run_req(3);   // same lane: draw only
      run_req(4);   // out of range: Err only
      chk("err_no_state_change_lane", 32'(model_lane), 32'd3);
      run_req(3);   // still no erase after rejected request

      // Abort a draw pass with reset at plot 20
      @(negedge Clock);
      clear_counts();
      push_pass(3, 3'b110);
      Start = 1'b1;
      Lane  = 4'd3;
      @(negedge Clock);
      Start = 1'b0;
      for (int i = 0; i < 100 && plot_cnt < 20; i++) @(negedge Clock);
      chk("reached_plot_20", 32'(plot_cnt >= 20), 32'd1);
      Reset = 1'b1;
      #1;
      chk("midreset_outputs", {14'd0, XOut, YOut, ColourOut}, 32'd0);
      chk("midreset_flags", {28'd0, Plot, Busy, Done, Err}, 32'd0);
      exp_q.delete();
      model_valid = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;
      run_req(0);   // no erase after reset, X 6..10

      // Start held high across a whole request
      @(negedge Clock);
      clear_counts();
      push_pass(0, 3'b110);
      push_pass(0, 3'b110);
      Start = 1'b1;
      Lane  = 4'd0;
      for (int i = 0; i < 200 && done_cnt == 0; i++) @(negedge Clock);
      chk("held_first_done", 32'(done_cnt), 32'd1);
      chk("held_first_plots", 32'(plot_cnt), 32'd45);
      for (int i = 0; i < 10 && Busy; i++) @(negedge Clock);
      gap = 0;
      for (int i = 0; i < 10 && !Busy; i++) begin
         gap++;
         @(negedge Clock);
      end
      Start = 1'b0;
      chk("held_idle_gap", 32'(gap), 32'd1);
      for (int i = 0; i < 200 && done_cnt < 2; i++) @(negedge Clock);
      repeat (3) @(negedge Clock);
      chk("held_done_count", 32'(done_cnt), 32'd2);
      chk("held_plot_count", 32'(plot_cnt), 32'd90);
      chk("held_err_count", 32'(err_cnt), 32'd0);
      chk("held_scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
